instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle control sequencer for the 9-bit core: fetches 9-bit instructions from the instruction ROM, decodes the 4-bit opcode field, and drives ALU, register-file, data-memory and branch-LUT control. It sits between the instruction ROM and the datapath (ALU, register file, data memory) and consumes the same opcode map the assembler emits.

## Interface
Parameters:
- PC_W, 8, program-counter / instruction-address width
- MEM_TIMEOUT, 16, max MEM-state cycles waiting for MemAck before error (≥1)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin execution at PC 0 (honoured only in IDLE or HALT)
- InstAddr  out  PC_W  instruction fetch address (= PC)
- InstIn  in  9  instruction from ROM, combinational read of InstAddr
- AluOp  out  4  IR[8:5], opcode to ALU
- Operand  out  5  IR[4:0]
- AluEn  out  1  ALU-op strobe
- AluFlag  in  1  ALU compare result, sampled on CMP
- RegWrEn  out  1  register-file write strobe
- MemReq  out  1  data-memory request, held until MemAck
- MemWrite  out  1  1 = store, 0 = load; valid while MemReq
- MemAck  in  1  data-memory completion
- LutIdx  out  5  branch-LUT index (= Operand)
- LutTarget  in  PC_W  branch target from LUT, combinational
- Done  out  1  program halted normally
- Error  out  1  halted on memory timeout
- InstCount  out  16  instructions retired since Start, wraps at 2^16

## Operation
- Instruction fields: opcode = IR[8:5], operand = IR[4:0]. Opcodes: 0000 RC_ADD, 0001 RC_SUB, 0010 RC_LSL, 0011 RC_LSR, 0100 RC_TRANSFER, 0101 RC_CUSTOM, 0110 REG_COPY, 0111 ADD, 1000 SUB, 1001 XOR, 1010 AND, 1011 LSL, 1100 LSR, 1101 MEM_OP, 1110 CMP, 1111 BRANCH.
- Internal state: FSM, PC (PC_W), IR (9), Flag (1), timeout counter, InstCount.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE: outputs quiet; Start → FETCH with PC=0, Flag=0, InstCount=0.
- FETCH: InstAddr=PC; IR ← InstIn at edge; → EXEC.
- EXEC by opcode:
  - 0000–1100: AluEn=1, RegWrEn=1; PC←PC+1; retire; → FETCH.
  - CMP: AluEn=1, RegWrEn=0; Flag←AluFlag; PC←PC+1; retire; → FETCH.
  - BRANCH, operand≠11111: PC←Flag ? LutTarget : PC+1; Flag←0; retire; → FETCH.
  - BRANCH, operand=11111 (halt, IR=9'h1FF): retire; → HALT, Done←1.
  - MEM_OP: MemWrite=IR[4] (IR[3:0] selects register); counter←0; → MEM.
- MEM: MemReq=1, MemWrite=IR[4]. On MemAck: RegWrEn=1 iff load; PC←PC+1; retire; → FETCH. No ack with counter=MEM_TIMEOUT−1 → HALT, Error←1, no retire; else counter+1.
- HALT: PC frozen; Done/Error held. Start → FETCH as from IDLE, clearing Done and Error.
- PC increment wraps modulo 2^PC_W (all-ones + 1 = 0).
- Start outside IDLE/HALT ignored. MemAck outside MEM ignored.

## Timing
- Reset (async, immediate): state IDLE, PC=0, IR=0, Flag=0, counter=0, InstCount=0, Done=0, Error=0; all strobes (AluEn, RegWrEn, MemReq, MemWrite) 0. InstAddr=0, AluOp=0, Operand=0, LutIdx=0.
- Reset mid-MEM drops MemReq asynchronously; no write issued.
- Strobes are combinational from state and IR; valid for exactly one cycle (EXEC), except MemReq (every MEM cycle).
- Latency: ALU/CMP/BRANCH = 2 cycles (FETCH, EXEC). MEM_OP = 3 + k cycles, k = MEM cycles before ack (ack in first MEM cycle → 3 cycles).
- Timeout: Error rises the cycle after MEM_TIMEOUT MEM cycles without ack.
- Start sampled at edge; first FETCH the following cycle.
- InstCount increments at the retiring edge; visible the next cycle.

## Test plan
- Reset mid-run then release: all outputs at reset values; Start → InstAddr=0 in the next cycle.
- ROM {ADD r1 (0111_00001), XOR (1001_00010), 9'h1FF}: AluEn/RegWrEn pulse in cycles 2 and 4; Done=1 after cycle 6; InstCount=3.
- CMP with AluFlag=1, then BRANCH idx 3 with LutTarget=8'h40: next InstAddr=0x40; repeat with AluFlag=0 → InstAddr=PC+1.
- Load (1101_0_0101), MemAck on 3rd MEM cycle: MemReq high 3 cycles, MemWrite=0, RegWrEn only on the ack cycle; PC+1. Store: RegWrEn never asserted.
- MEM_TIMEOUT=4, MemAck never: MemReq high 4 cycles, then HALT with Error=1, Done=0; Start clears Error and refetches PC 0.
- PC_W=4, 16 ALU ops with no halt: InstAddr wraps 15→0; InstCount=16.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 9-bit core: FETCH, EXEC, optional MEM wait, HALT.
// Strobes are decoded combinationally from state and IR; Done/Error and all architectural state are registered.
module instr_sequencer #(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic [PC_W-1:0] InstAddr,
  input  logic [8:0]      InstIn,
  output logic [3:0]      AluOp,
  output logic [4:0]      Operand,
  output logic            AluEn,
  input  logic            AluFlag,
  output logic            RegWrEn,
  output logic            MemReq,
  output logic            MemWrite,
  input  logic            MemAck,
  output logic [4:0]      LutIdx,
  input  logic [PC_W-1:0] LutTarget,
  output logic            Done,
  output logic            Error,
  output logic [15:0]     InstCount
);

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_RC_ADD      = 4'b0000,
    OP_RC_SUB      = 4'b0001,
    OP_RC_LSL      = 4'b0010,
    OP_RC_LSR      = 4'b0011,
    OP_RC_TRANSFER = 4'b0100,
    OP_RC_CUSTOM   = 4'b0101,
    OP_REG_COPY    = 4'b0110,
    OP_ADD         = 4'b0111,
    OP_SUB         = 4'b1000,
    OP_XOR         = 4'b1001,
    OP_AND         = 4'b1010,
    OP_LSL         = 4'b1011,
    OP_LSR         = 4'b1100,
    OP_MEM         = 4'b1101,
    OP_CMP         = 4'b1110,
    OP_BRANCH      = 4'b1111
  } opcode_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic            flag;
  logic [TO_W-1:0] tmo_cnt;
  logic [15:0]     inst_count;
  logic            done_q;
  logic            error_q;

  opcode_t         opcode;
  logic            is_alu_op;
  logic            is_halt;
  logic [PC_W-1:0] pc_next_seq;

  assign opcode      = opcode_t'(ir[8:5]);
  assign is_alu_op   = (ir[8:5] <= OP_LSR);
  assign is_halt     = (ir[4:0] == 5'h1F);
  assign pc_next_seq = pc + PC_W'(1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      flag       <= 1'b0;
      tmo_cnt    <= '0;
      inst_count <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state      <= S_FETCH;
            pc         <= '0;
            flag       <= 1'b0;
            inst_count <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end

        S_FETCH: begin
          ir    <= InstIn;
          state <= S_EXEC;
        end

        S_EXEC: begin
          if (is_alu_op) begin
            pc         <= pc_next_seq;
            inst_count <= inst_count + 16'd1;
            state      <= S_FETCH;
          end else begin
            case (opcode)
              OP_CMP: begin
                flag       <= AluFlag;
                pc         <= pc_next_seq;
                inst_count <= inst_count + 16'd1;
                state      <= S_FETCH;
              end
              OP_BRANCH: begin
                inst_count <= inst_count + 16'd1;
                if (is_halt) begin
                  done_q <= 1'b1;
                  state  <= S_HALT;
                end else begin
                  // Flag is consumed by the branch so a stale compare cannot steer a later one.
                  pc    <= flag ? LutTarget : pc_next_seq;
                  flag  <= 1'b0;
                  state <= S_FETCH;
                end
              end
              default: begin
                tmo_cnt <= '0;
                state   <= S_MEM;
              end
            endcase
          end
        end

        S_MEM: begin
          if (MemAck) begin
            pc         <= pc_next_seq;
            inst_count <= inst_count + 16'd1;
            state      <= S_FETCH;
          end else if (tmo_cnt == TO_LAST) begin
            error_q <= 1'b1;
            state   <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    AluEn    = 1'b0;
    RegWrEn  = 1'b0;
    MemReq   = 1'b0;
    MemWrite = 1'b0;
    case (state)
      S_EXEC: begin
        AluEn    = is_alu_op || (opcode == OP_CMP);
        RegWrEn  = is_alu_op;
        MemWrite = (opcode == OP_MEM) && ir[4];
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemWrite = ir[4];
        RegWrEn  = MemAck && !ir[4];
      end
      default: ;
    endcase
  end

  assign InstAddr  = pc;
  assign AluOp     = ir[8:5];
  assign Operand   = ir[4:0];
  assign LutIdx    = ir[4:0];
  assign Done      = done_q;
  assign Error     = error_q;
  assign InstCount = inst_count;

endmodule
